forwarding_unit: RTL

Execute-stage forwarding and load-use hazard unit. It tracks the destination tags of the in-flight instructions in the EX, MEM and WB slots and produces registered `alu_src1_select`/`alu_src2_select` codes for the ALU operand muxes, aligned with the instruction occupying EX. It also raises a one-cycle stall on load-use hazards and keeps a saturating stall counter for performance monitoring.

---
 rtl/forwarding_unit.sv | 105 ++++++++++
 1 files changed

// File: rtl/forwarding_unit.sv
// rtl/forwarding_unit.sv - execute-stage operand forwarding and load-use hazard unit
module forwarding_unit #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   id_valid,
  input  logic [2:0]             id_src1,
  input  logic [2:0]             id_src2,
  input  logic                   id_uses_src1,
  input  logic                   id_uses_src2,
  input  logic                   id_imm,
  input  logic [2:0]             id_dest,
  input  logic                   id_writes_reg,
  input  logic                   id_is_load,
  input  logic                   id_is_in,
  output logic [2:0]             alu_src1_select,
  output logic [2:0]             alu_src2_select,
  output logic                   stall,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam logic [2:0] SEL_WB       = 3'b000;
  localparam logic [2:0] SEL_EXMEM    = 3'b001;
  localparam logic [2:0] SEL_RF       = 3'b010;
  localparam logic [2:0] SEL_EXMEM_IN = 3'b011;
  localparam logic [2:0] SEL_MEMWB_IN = 3'b100;

  typedef struct packed {
    logic       valid;
    logic [2:0] dest;
    logic       writes_reg;
    logic       is_load;
    logic       is_in;
  } slot_t;

  slot_t                   ex_q, mem_q, wb_q, ex_d;
  logic [2:0]              sel1_q, sel2_q, sel1_d, sel2_d;
  logic [STALL_CNT_W-1:0]  cnt_q, cnt_d;
  logic                    use2, hazard, issue;
  logic                    unused_slot_bits;

  // Current EX slot is MEM when the consumer executes; current MEM slot is WB.
  function automatic logic [2:0] fwd_sel(input logic used, input logic [2:0] src,
                                         input slot_t ex, input slot_t mem);
    logic [2:0] sel;
    sel = SEL_RF;
    if (used) begin
      if (ex.valid && ex.writes_reg && !ex.is_load && ex.dest == src)
        sel = ex.is_in ? SEL_EXMEM_IN : SEL_EXMEM;
      else if (mem.valid && mem.writes_reg && mem.dest == src)
        sel = mem.is_in ? SEL_MEMWB_IN : SEL_WB;
    end
    return sel;
  endfunction

  assign use2   = id_uses_src2 & ~id_imm;
  assign hazard = id_valid & ex_q.valid & ex_q.writes_reg & ex_q.is_load &
                  ((id_uses_src1 & (ex_q.dest == id_src1)) |
                   (use2 & (ex_q.dest == id_src2)));
  assign stall  = hazard & ~flush;
  assign issue  = id_valid & ~stall & ~flush;

  always_comb begin
    ex_d   = '0;
    sel1_d = SEL_RF;
    sel2_d = SEL_RF;
    if (issue) begin
      ex_d   = '{valid: 1'b1, dest: id_dest, writes_reg: id_writes_reg,
                 is_load: id_is_load, is_in: id_is_in};
      sel1_d = fwd_sel(id_uses_src1, id_src1, ex_q, mem_q);
      sel2_d = fwd_sel(use2, id_src2, ex_q, mem_q);
    end
    cnt_d = cnt_q;
    if (stall && cnt_q != {STALL_CNT_W{1'b1}})
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q   <= '0;
      mem_q  <= '0;
      wb_q   <= '0;
      sel1_q <= SEL_RF;
      sel2_q <= SEL_RF;
      cnt_q  <= '0;
    end else begin
      ex_q   <= ex_d;
      mem_q  <= ex_q;
      wb_q   <= mem_q;
      sel1_q <= sel1_d;
      sel2_q <= sel2_d;
      cnt_q  <= cnt_d;
    end
  end

  // WB slot is tracked for completeness but its producer reaches the register file directly.
  assign unused_slot_bits = ^{wb_q, mem_q.is_load};

  assign alu_src1_select = sel1_q;
  assign alu_src2_select = sel2_q;
  assign stall_count     = cnt_q;

endmodule
